// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: captures execute results for the memory stage,
// resolves branch/JAL/JALR into a one-cycle front-end redirect, and squashes wrong-path work.
module ex_mem_stage #(
  parameter int XLEN   = 32,
  parameter int SHADOW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_stall,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] alu_result,
  input  logic            branch,
  input  logic            ex_is_branch,
  input  logic            ex_is_jal,
  input  logic            ex_is_jalr,
  input  logic [XLEN-1:0] ex_rs2_data,
  input  logic [4:0]      ex_rd,
  input  logic            ex_reg_write,
  input  logic            ex_mem_read,
  input  logic            ex_mem_write,
  input  logic [2:0]      ex_funct3,
  output logic            mem_valid,
  output logic [XLEN-1:0] mem_result,
  output logic [XLEN-1:0] mem_store_data,
  output logic [4:0]      mem_rd,
  output logic            mem_reg_write,
  output logic            mem_mem_read,
  output logic            mem_mem_write,
  output logic [2:0]      mem_funct3,
  output logic            mem_misalign,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush_if_id,
  output logic            fwd_en,
  output logic [4:0]      fwd_rd,
  output logic [XLEN-1:0] fwd_data
);

  typedef enum logic {RUN, SQUASH} state_t;

  state_t          state;
  logic [2:0]      squash_cnt;
  logic            taken;
  logic            tgt_misalign;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] link;

  always_comb begin
    taken  = ex_valid & (ex_is_jal | ex_is_jalr | (ex_is_branch & branch));
    target = ex_is_jalr ? {alu_result[XLEN-1:1], 1'b0} : ex_pc + ex_imm;
    link   = ex_pc + XLEN'(4);
    tgt_misalign = taken & target[1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= RUN;
      squash_cnt     <= '0;
      mem_valid      <= 1'b0;
      mem_result     <= '0;
      mem_store_data <= '0;
      mem_rd         <= '0;
      mem_reg_write  <= 1'b0;
      mem_mem_read   <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_funct3     <= '0;
      mem_misalign   <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      // Pulse drops on every edge, stalled or not, so it is never repeated.
      redirect_valid <= 1'b0;
      if (!mem_stall) begin
        if (state == SQUASH) begin
          mem_valid     <= 1'b0;
          mem_reg_write <= 1'b0;
          mem_mem_read  <= 1'b0;
          mem_mem_write <= 1'b0;
          mem_misalign  <= 1'b0;
          squash_cnt    <= squash_cnt - 3'd1;
          if (squash_cnt == 3'd1)
            state <= RUN;
        end else begin
          mem_valid     <= ex_valid;
          mem_reg_write <= ex_valid & ex_reg_write & ~tgt_misalign;
          mem_mem_read  <= ex_valid & ex_mem_read;
          mem_mem_write <= ex_valid & ex_mem_write;
          mem_misalign  <= tgt_misalign;
          if (ex_valid) begin
            mem_result     <= (ex_is_jal | ex_is_jalr) ? link : alu_result;
            mem_store_data <= ex_rs2_data;
            mem_rd         <= ex_rd;
            mem_funct3     <= ex_funct3;
          end
          if (taken && !target[1]) begin
            redirect_valid <= 1'b1;
            redirect_pc    <= target;
            state          <= SQUASH;
            squash_cnt     <= 3'(SHADOW);
          end
        end
      end
    end
  end

  always_comb begin
    flush_if_id = redirect_valid;
    fwd_en      = mem_valid & mem_reg_write & (mem_rd != 5'd0);
    fwd_rd      = mem_rd;
    fwd_data    = mem_result;
  end

endmodule
